// File: rtl/pipe_fetch_ctrl.sv
// IF-stage sequencer: PC register, imem handshake, next-PC select, IF/ID load.
// Define FETCH_PERF_EN to add the fetch_cnt / stall_cnt performance counters.
module pipe_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] d_ins,
  output logic [31:0] d_pc4,
  output logic        d_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic [31:0] buffer;
  logic [31:0] pc4, npc, eff_npc;
  logic [1:0]  sel;
  logic        pc_upd, latch_new, latch_buf;
  logic        bubble, park, capture;

  assign pc4     = pc + 32'd4;
  assign sel     = (d_valid && wpcir) ? pcsource : 2'd0;
  assign eff_npc = redir_v ? redir_pc : npc;

  always_comb begin
    npc = pc4;
    unique case (sel)
      2'd0: npc = pc4;
      2'd1: npc = bpc;
      2'd2: npc = da;
      2'd3: npc = jpc;
    endcase
  end

  assign latch_new = (state == FETCH) && imem_ready && wpcir;
  assign park      = (state == FETCH) && imem_ready && !wpcir;
  assign bubble    = (state == FETCH) && !imem_ready && wpcir;
  assign latch_buf = (state == HOLD) && wpcir;
  assign pc_upd    = latch_new || latch_buf;

  // Branch left ID but its delay slot is still pending: remember target.
  assign capture = d_valid && wpcir && (pcsource != 2'd0) && !pc_upd;

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: if (park)  state_nx = HOLD;
      HOLD:  if (wpcir) state_nx = FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      FETCH: imem_req = !reset;
      HOLD:  imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      d_ins    <= NOP_INS;
      d_pc4    <= 32'd0;
      d_valid  <= 1'b0;
      redir_v  <= 1'b0;
      redir_pc <= 32'd0;
      buffer   <= 32'd0;
    end else begin
      if (latch_new) begin
        d_ins   <= imem_rdata;
        d_pc4   <= pc4;
        d_valid <= 1'b1;
      end else if (latch_buf) begin
        d_ins   <= buffer;
        d_pc4   <= pc4;
        d_valid <= 1'b1;
      end else if (bubble) begin
        d_ins   <= NOP_INS;
        d_valid <= 1'b0;
      end
      if (park) buffer <= imem_rdata;
      if (pc_upd) begin
        pc      <= eff_npc;
        redir_v <= 1'b0;
      end else if (capture) begin
        redir_v  <= 1'b1;
        redir_pc <= npc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (pc_upd) fetch_cnt <= fetch_cnt + 32'd1;
      if (imem_req && !imem_ready)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_fetch_ctrl.md
Name: pipe_fetch_ctrl

Overview:
Sequences the IF stage of the 5-stage pipelined CPU. It owns the PC register, issues requests to an instruction memory that may take several cycles, and selects the next PC from pc+4, branch, jr or jump targets. It loads the IF/ID register and honours the hazard unit's stall signal (wpcir). It remembers a branch or jump redirect resolved in ID while the delay-slot fetch is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INS, 32'h0000_0000, instruction word placed in IF/ID on a bubble

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
pcsource  in  2  next-PC select from ID: 0 pc+4, 1 bpc, 2 da, 3 jpc
bpc  in  32  beq/bne target
da  in  32  jr register value
jpc  in  32  j/jal target
wpcir  in  1  1 = IF/ID and PC may advance; 0 = stall from the hazard unit
imem_req  out  1  fetch request, held until imem_ready
imem_addr  out  32  fetch address, equal to pc
imem_rdata  in  32  instruction, valid when imem_ready=1
imem_ready  in  1  fetch complete this cycle
pc  out  32  current fetch PC
d_ins  out  32  IF/ID instruction
d_pc4  out  32  IF/ID pc+4
d_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). All state updates occur on the rising edge of clock.
- Reset values: pc=RESET_PC; d_ins=NOP_INS; d_pc4=0; d_valid=0; redir_v=0; redir_pc=0; hold buffer=0; state=FETCH. imem_req is 0 during the reset cycle and is 1 from the first cycle after reset.
- npc computation: selected from pc+4, bpc, da and jpc by pcsource. Arithmetic is 32-bit, wraps at 2^32, with no alignment check.
- Effective next PC: redir_pc if redir_v=1, otherwise npc.
- FETCH state: imem_req=1, imem_addr=pc.
  - imem_ready & wpcir: d_ins<=imem_rdata, d_pc4<=pc+4, d_valid<=1, pc<=effective next PC, redir_v<=0.
  - imem_ready & !wpcir: buffer<=imem_rdata, IF/ID unchanged, pc unchanged, go to HOLD.
  - !imem_ready & wpcir: bubble. d_ins<=NOP_INS, d_valid<=0, pc unchanged.
  - !imem_ready & !wpcir: everything holds.
- HOLD state: imem_req=0. When wpcir=1: IF/ID<={buffer, pc+4, 1}, pc<=effective next PC, redir_v<=0, go to FETCH.
- Redirect capture: when d_valid & wpcir & pcsource!=0 and pc does not update in that cycle, set redir_v<=1 and redir_pc<=npc. The branch leaves ID; the delay slot is still in flight.
- A redirect arriving while redir_v=1 overwrites redir_pc (the last redirect wins).
- pcsource is ignored when d_valid=0 or wpcir=0.
- Delayed-branch semantics: the instruction at branch+4 is never squashed.
- Reset mid-fetch: the outstanding request is abandoned and the memory response in that cycle is discarded. The next request is to RESET_PC.
- The effective next PC is registered when pc updates. The instruction memory sees the new pc one cycle later.
- Zero-wait memory (imem_ready always 1) gives 1 instruction per cycle with no bubbles.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds 32-bit outputs fetch_cnt (pc updates) and stall_cnt (cycles with imem_req=1 & !imem_ready). Both clear on reset and wrap at 2^32.
- Undefined: these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Zero-wait sequential fetch: reset with RESET_PC=0, imem_ready=1, wpcir=1, pcsource=0 for 4 cycles -> imem_addr=0,4,8,C; d_pc4=4,8,C,10; d_valid=1 from cycle 2.
- Wait states: imem_ready low for 2 cycles at pc=8 -> d_valid=0 with d_ins=NOP_INS for 2 cycles; pc stays 8; d_ins=mem[8] once ready.
- Stall with data ready: wpcir=0 for 3 cycles while imem_ready=1 at pc=10 -> state HOLD, imem_req=0, IF/ID unchanged; on wpcir=1 d_ins=mem[10], pc=14.
- Immediate branch: d_valid=1, pcsource=1, bpc=40, imem_ready=1 -> delay slot fetched and latched, next pc=40.
- Deferred redirect: pcsource=3, jpc=100 while the delay-slot fetch waits 3 cycles -> redir_v=1; after ready, pc=100 and redir_v=0.
- Reset mid-operation: assert reset while in HOLD with redir_v=1 -> pc=RESET_PC, d_valid=0, redir_v=0, state FETCH; with FETCH_PERF_EN both counters read 0.
